// File: rtl/alu_result_demux.sv
// alu_result_demux: steers one ALU result stream to one of two consumers.
//   out0 = register-file writeback, out1 = store/memory path.
// Each destination owns a 2-entry FIFO with a valid/ready handshake, so a
// stalled consumer never blocks or corrupts the other path.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid/in_ready    upstream handshake (in_ready reflects the buffer picked by in_sel)
//   in_sel, in_data      destination select (0 -> out0, 1 -> out1) and word
//   outN_valid/ready     downstream handshake per destination
//   outN_data            head word of each buffer (registered)
//   cnt0, cnt1           completed-pop counters, present only with ALU_DEMUX_COUNT_EN
//
// Optional feature macro: ALU_DEMUX_COUNT_EN (adds cnt0/cnt1 16-bit pop counters).
module alu_result_demux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
`ifdef ALU_DEMUX_COUNT_EN
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1,
`endif
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
);

  // Pointers are one bit wide, so the buffer depth is fixed at two.
  localparam logic [1:0] FullCnt = 2'(DEPTH);

  // Indexing below is [port][entry].
  logic [1:0][1:0][WIDTH-1:0] mem_q, mem_d;
  logic [1:0]                 rptr_q, rptr_d;
  logic [1:0]                 wptr_q, wptr_d;
  logic [1:0][1:0]            cnt_q, cnt_d;
  logic [1:0]                 full;
  logic [1:0]                 push;
  logic [1:0]                 pop;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      full[p] = (cnt_q[p] == FullCnt);
    end
  end

  // Depends only on registered counts and in_sel: no ready path from the outputs.
  assign in_ready = ~full[in_sel];

  // in_valid gates everything, so an X on in_sel/in_data while idle cannot move state.
  assign push[0] = in_valid & in_ready & ~in_sel;
  assign push[1] = in_valid & in_ready & in_sel;

  assign out0_valid = (cnt_q[0] != 2'd0);
  assign out1_valid = (cnt_q[1] != 2'd0);
  assign out0_data  = mem_q[0][rptr_q[0]];
  assign out1_data  = mem_q[1][rptr_q[1]];

  assign pop[0] = out0_valid & out0_ready;
  assign pop[1] = out1_valid & out1_ready;

  always_comb begin
    mem_d  = mem_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    for (int p = 0; p < 2; p++) begin
      if (push[p]) begin
        mem_d[p][wptr_q[p]] = in_data;
        wptr_d[p]           = ~wptr_q[p];
      end
      if (pop[p]) begin
        rptr_d[p] = ~rptr_q[p];
      end
      // Push and pop together leave the count unchanged.
      cnt_d[p] = cnt_q[p] + 2'(push[p]) - 2'(pop[p]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef ALU_DEMUX_COUNT_EN
  logic [1:0][15:0] pops_q;

  // Free-running, wraps at 16'hFFFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pops_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        pops_q[p] <= pops_q[p] + 16'(pop[p]);
      end
    end
  end

  assign cnt0 = pops_q[0];
  assign cnt1 = pops_q[1];
`endif

endmodule

// File: tb/tb_alu_result_demux.sv
module tb_alu_result_demux;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_sel;
  logic [W-1:0] in_data;
  logic         out0_valid;
  logic         out0_ready;
  logic [W-1:0] out0_data;
  logic         out1_valid;
  logic         out1_ready;
  logic [W-1:0] out1_data;
`ifdef ALU_DEMUX_COUNT_EN
  logic [15:0]  cnt0;
  logic [15:0]  cnt1;
`endif

  alu_result_demux #(.WIDTH(W), .DEPTH(2)) dut (
`ifdef ALU_DEMUX_COUNT_EN
    .cnt0       (cnt0),
    .cnt1       (cnt1),
`endif
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model: each destination is simply a queue holding at most two words.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int unsigned  pops0 = 0;
  int unsigned  pops1 = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic sel);
    chk("out0_valid", W'(out0_valid), W'(q0.size() != 0));
    chk("out1_valid", W'(out1_valid), W'(q1.size() != 0));
    if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
    if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
    if (!$isunknown(sel))
      chk("in_ready", W'(in_ready), W'(sel ? (q1.size() < 2) : (q0.size() < 2)));
  endtask

  // One clock cycle: drive, check against the model, clock, advance the model.
  task automatic step(input logic iv, input logic sel, input logic [W-1:0] d,
                      input logic r0, input logic r1);
    logic acc, p0, p1;
    in_valid   = iv;
    in_sel     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    check_outputs(sel);
    acc = iv && (sel ? (q1.size() < 2) : (q0.size() < 2));
    p0  = (q0.size() != 0) && r0;
    p1  = (q1.size() != 0) && r1;
    @(posedge clk);
    if (p0) begin void'(q0.pop_front()); pops0++; end
    if (p1) begin void'(q1.pop_front()); pops1++; end
    if (acc === 1'b1) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
    end
    #1;
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    pops0 = 0;
    pops1 = 0;
  endtask

  initial begin
    logic         iv, s, r0, r1;
    logic [W-1:0] d;

    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    // Reset then idle.
    chk("rst_out0_valid", W'(out0_valid), '0);
    chk("rst_out1_valid", W'(out1_valid), '0);
    chk("rst_out0_data", out0_data, '0);
    chk("rst_out1_data", out1_data, '0);
    in_sel = 1'b0; #1 chk("rst_in_ready_sel0", W'(in_ready), W'(1));
    in_sel = 1'b1; #1 chk("rst_in_ready_sel1", W'(in_ready), W'(1));
    @(posedge clk) #1;

    // Steering.
    step(1'b1, 1'b0, 32'h0000_00AA, 1'b1, 1'b1);
    chk("steer_out0_aa", out0_data, 32'h0000_00AA);
    step(1'b1, 1'b1, 32'h0000_00BB, 1'b1, 1'b1);
    chk("steer_out1_bb", out1_data, 32'h0000_00BB);
    chk("steer_no_cross", W'(out0_valid), '0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Fill and stall out0, route around it to out1.
    step(1'b1, 1'b0, 32'h11, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h22, 1'b0, 1'b0);
    in_sel = 1'b0; in_valid = 1'b1; in_data = 32'h33; #1;
    chk("full_in_ready0", W'(in_ready), '0);
    step(1'b1, 1'b1, 32'h44, 1'b0, 1'b0);
    chk("out1_got_44", out1_data, 32'h44);

    // Drain in order; 33 goes in once in_ready returns.
    step(1'b1, 1'b0, 32'h33, 1'b1, 1'b0);
    chk("drain_22_head", out0_data, 32'h22);
    step(1'b1, 1'b0, 32'h33, 1'b1, 1'b0);
    chk("drain_33_head", out0_data, 32'h33);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Streaming through out1.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, W'(i), 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Randomized traffic, including X on in_sel/in_data while idle.
    for (int i = 0; i < 400; i++) begin
      iv = 1'($urandom_range(0, 1));
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      if (iv || $urandom_range(0, 1) == 0) begin
        s = 1'($urandom_range(0, 1));
        d = $urandom;
      end else begin
        s = 1'bx;
        d = 'x;
      end
      step(iv, s, d, r0, r1);
    end

`ifdef ALU_DEMUX_COUNT_EN
    chk("cnt0", W'(cnt0), W'(pops0[15:0]));
    chk("cnt1", W'(cnt1), W'(pops1[15:0]));
`endif

    // Reset mid-operation with both buffers full.
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'hA1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hA2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hB1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hB2, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out0_valid", W'(out0_valid), '0);
    chk("async_rst_out1_valid", W'(out1_valid), '0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    chk("post_rst_out0_data", out0_data, '0);
    chk("post_rst_out1_data", out1_data, '0);
`ifdef ALU_DEMUX_COUNT_EN
    chk("post_rst_cnt0", W'(cnt0), '0);
    chk("post_rst_cnt1", W'(cnt1), '0);
`endif
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 32'hC0DE, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute time limit so a broken design cannot hang the run.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
